// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage.
// Opcodes, request FSM state encoding and timeout default.
package mem_pkg;

   localparam logic [3:0] OP_LW = 4'b0100;
   localparam logic [3:0] OP_SW = 4'b0101;
   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_WAIT_R = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request FSM: handshake, stall, flush drain and timeout.
// Reports completed loads/stores to the stage for writeback.
module dmem_req_fsm
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              mem_stall,
   output logic              mem_err,
   output logic              idle,
   output logic              load_done,
   output logic              store_done
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [1:0] nxt;
   logic [7:0] cnt;
   logic       abort;

   always_comb begin
      nxt        = state;
      load_done  = 1'b0;
      store_done = 1'b0;
      abort      = 1'b0;
      unique case (state)
         ST_IDLE: if (start) nxt = ST_REQ;
         ST_REQ: begin
            if (flush) begin
               // an accepted load still owes one rvalid
               if (dmem_ready && !we && !dmem_rvalid)
                  nxt = ST_DRAIN;
               else
                  nxt = ST_IDLE;
            end else if (dmem_ready) begin
               if (we) begin
                  store_done = 1'b1;
                  nxt        = ST_IDLE;
               end else if (dmem_rvalid) begin
                  load_done = 1'b1;
                  nxt       = ST_IDLE;
               end else begin
                  nxt = ST_WAIT_R;
               end
            end
         end
         ST_WAIT_R: begin
            if (dmem_rvalid) begin
               load_done = !flush;
               nxt       = ST_IDLE;
            end else if (flush) begin
               nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: if (dmem_rvalid) nxt = ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
      if (state != ST_IDLE && nxt != ST_IDLE && cnt == TMO_LAST) begin
         abort = 1'b1;
         nxt   = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= nxt;
         mem_err <= abort;
         if (state == ST_IDLE || nxt == ST_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;
      end
   end

   assign dmem_req   = (state == ST_REQ);
   assign dmem_we    = dmem_req & we;
   assign dmem_addr  = addr;
   assign dmem_wdata = wdata;
   assign mem_stall  = (state != ST_IDLE);
   assign idle       = (state == ST_IDLE);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the request and muxes the
// registered writeback (ALU pass-through or load data).
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_ctrl_mem,
   input  logic              flush,
   input  logic              valid_ex,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic [ADDR_W-1:0] ls_mem_addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic              wb_valid_in,
   input  logic [DATA_W-1:0] wb_data_in,
   input  logic [2:0]        wb_addr_in,
   input  logic [3:0]        opcode_ex,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        wb_addr,
   output logic [3:0]        opcode_mem,
   output logic              valid_out,
   output logic              mem_err
);

   logic              idle;
   logic              load_done;
   logic              store_done;
   logic              go;
   logic              go_mem;
   logic              go_alu;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [2:0]        rd_q;
   logic [3:0]        op_q;

   // stores arrive with valid_ex low, so mem_r/mem_w also mark a slot
   assign go     = idle & en_ctrl_mem & !flush & (valid_ex | mem_r | mem_w);
   assign go_mem = go & (mem_r | mem_w);
   assign go_alu = go & !(mem_r | mem_w);

   dmem_req_fsm #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .start      (go_mem),
      .flush      (flush),
      .we         (we_q),
      .addr       (addr_q),
      .wdata      (wdata_q),
      .dmem_ready (dmem_ready),
      .dmem_rvalid(dmem_rvalid),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .mem_stall  (mem_stall),
      .mem_err    (mem_err),
      .idle       (idle),
      .load_done  (load_done),
      .store_done (store_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         op_q    <= '0;
      end else if (go_mem) begin
         addr_q  <= ls_mem_addr;
         wdata_q <= store_data;
         we_q    <= mem_w;
         rd_q    <= wb_addr_in;
         op_q    <= opcode_ex;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_addr    <= '0;
         opcode_mem <= '0;
         valid_out  <= 1'b0;
      end else if (load_done) begin
         wb_valid   <= 1'b1;
         wb_data    <= dmem_rdata;
         wb_addr    <= rd_q;
         opcode_mem <= op_q;
         valid_out  <= 1'b1;
      end else if (store_done) begin
         wb_valid   <= 1'b0;
         wb_addr    <= rd_q;
         opcode_mem <= op_q;
         valid_out  <= (op_q == OP_SM);
      end else if (!idle || en_ctrl_mem) begin
         if (go_alu) begin
            wb_valid   <= wb_valid_in;
            wb_data    <= wb_data_in;
            wb_addr    <= wb_addr_in;
            opcode_mem <= opcode_ex;
            valid_out  <= valid_ex;
         end else begin
            wb_valid  <= 1'b0;
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; consumes the execute stage's registered outputs: mem_r/mem_w, ls_mem_addr, store_data, writeback_*, opcode_ex, valid_out.
- Drives a variable-latency data-memory request/response interface.
- Stalls the upstream pipeline while a transaction is in flight.
- Delivers registered writeback results (ALU pass-through or load data) to the writeback stage.

Parameters:
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data word width
- TIMEOUT, 255, max cycles a transaction may stay in REQ+WAIT_R before abort (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en_ctrl_mem  in  1  stage enable from control unit; low = freeze outputs
- flush  in  1  kill current/in-flight instruction
- valid_ex  in  1  execute-stage valid_out
- mem_r  in  1  load request
- mem_w  in  1  store request
- ls_mem_addr  in  ADDR_W  load/store address
- store_data  in  DATA_W  store data
- wb_valid_in  in  1  execute writeback_valid
- wb_data_in  in  DATA_W  execute writeback_data
- wb_addr_in  in  3  execute writeback_addr
- opcode_ex  in  4  execute opcode
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  request address
- dmem_wdata  out  DATA_W  write data
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data
- mem_stall  out  1  freeze upstream stages
- wb_valid  out  1  writeback enable to WB stage
- wb_data  out  DATA_W  writeback data
- wb_addr  out  3  destination register
- opcode_mem  out  4  opcode of instruction leaving stage
- valid_out  out  1  instruction completed this cycle
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset:
  - State IDLE; timeout counter 0.
  - All outputs 0 (dmem_*, wb_*, opcode_mem, valid_out, mem_err, mem_stall).
  - Reset mid-transaction abandons it; no drain.
- Slot valid = valid_ex | mem_r | mem_w. Stores arrive with valid_ex=0 and must still be accepted.
- Accept condition: state IDLE & en_ctrl_mem & !flush & slot valid.
- mem_stall is combinational: high iff state ∈ {REQ, WAIT_R, DRAIN}. It is low in the accept cycle: upstream advances once, then holds its next instruction until the stage returns to IDLE.
- Non-memory accept (mem_r=mem_w=0):
  - Next cycle: wb_valid=wb_valid_in, wb_data=wb_data_in, wb_addr=wb_addr_in, opcode_mem=opcode_ex, valid_out=valid_ex.
  - Latency 1.
- Memory accept: latch addr, wdata, we=mem_w, wb_addr, opcode; go to REQ. wb_valid/valid_out are 0 next cycle.
- REQ:
  - dmem_req=1; dmem_we/addr/wdata stable until dmem_ready.
  - On ready with store: go IDLE; next cycle valid_out=1 for SM (0111), 0 for SW (0101); wb_valid=0.
  - On ready with load and rvalid in the same cycle: complete immediately (see WAIT_R).
  - On ready with load otherwise: go WAIT_R; dmem_req drops.
- WAIT_R: on dmem_rvalid, register wb_data=dmem_rdata, wb_valid=1, valid_out=1, opcode_mem=latched; go IDLE.
- wb_valid and valid_out are single-cycle pulses per completed instruction; otherwise 0 while stage busy.
- Timeout:
  - Counter increments each cycle in REQ/WAIT_R, clears on entry to IDLE.
  - When counter==TIMEOUT-1 without completion: mem_err pulses next cycle, wb_valid=0, state→IDLE.
- Flush:
  - In IDLE: blocks accept.
  - In REQ without ready: drop request, go IDLE.
  - In REQ with ready (store) or in REQ/WAIT_R with a load already accepted: suppress completion. A load whose rvalid is still outstanding goes to DRAIN; it discards exactly one rvalid, then IDLE.
  - DRAIN obeys the same timeout.
- en_ctrl_mem low in IDLE: hold all registered outputs. When busy, the transaction continues regardless of en_ctrl_mem.
- Simultaneous dmem_ready & flush: flush wins; a write already handshaked is not undone, but no completion is reported.

Decomposition:
- Shared package mem_pkg:
  - Opcode constants LW=4'b0100, SW=4'b0101, LM=4'b0110, SM=4'b0111.
  - State encoding IDLE/REQ/WAIT_R/DRAIN.
  - TIMEOUT default.
- One sub-module, dmem_req_fsm: owns state, timeout counter, dmem_* handshake, mem_stall, mem_err.
- mem_stage: owns latch registers and writeback output mux.

Test Plan:
- ADD pass-through: valid_ex=1, wb_valid_in=1, data 0x1234, addr 3, opcode 0000 → next cycle wb_valid=1, wb_data=0x1234, wb_addr=3, valid_out=1; dmem_req never high.
- LW at 0x0040: dmem_ready after 2 cycles, rvalid 1 cycle later with 0xBEEF → dmem_req high exactly 3 cycles; mem_stall high 4 cycles; then wb_valid=1, wb_data=0xBEEF, opcode_mem=0100.
- SW addr 0x0010, data 0x00AA, valid_ex=0, dmem_ready immediate → one cycle dmem_req=1, we=1, addr 0x0010, wdata 0x00AA; wb_valid=0, valid_out=0. SM repeat → valid_out=1.
- LW then held ADD (data 0x0007): ADD must appear at outputs exactly one cycle after the LW's wb pulse; no duplication, no loss.
- Flush in WAIT_R, then rvalid with 0xDEAD → stage in DRAIN; 0xDEAD discarded; wb_valid stays 0; IDLE next cycle.
- TIMEOUT=4, LW with dmem_ready held low → mem_err pulses once after 4 busy cycles; wb_valid=0; mem_stall drops. Separately, rst asserted in WAIT_R → all outputs 0 next cycle.
